clk_step_ctrl: RTL and testbench
================================

# clk_step_ctrl

Run/halt/single-step controller for the gated DUT clock. Lives in the free-running MMCM 166 MHz domain and drives the BUFGCE clock-enable that produces the gated DUT clock. Arbitrates between a host command interface (run, halt, step N cycles) and the JTAG Run-Test/Idle run request, supports a cycle-count breakpoint, and counts gated cycles delivered to the DUT.

## Interface
Parameters:
- CNT_W, 32, width of step count, breakpoint and cycle counter
- SYNC_STAGES, 2, flop stages on the asynchronous jtag_run input (min 2)

Ports:
- clk  in  1  free-running 166 MHz MMCM output; the one clock of this block
- rstn  in  1  reset, asynchronous assert, active-low
- jtag_run  in  1  asynchronous level request, sel && runtest && !tms from BSCANE2
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0 NOP, 1 HALT, 2 RUN, 3 STEP
- cmd_count  in  CNT_W  number of gated cycles for STEP
- bp_en  in  1  breakpoint enable
- bp_cycle  in  CNT_W  breakpoint value compared against en_cycles
- gate_en  out  1  registered BUFGCE CE
- state  out  2  0 HALT, 1 RUN, 2 STEP, 3 JTAG
- step_done  out  1  one-cycle pulse, STEP completed
- bp_hit  out  1  one-cycle pulse, breakpoint halted the clock
- en_cycles  out  CNT_W  number of cycles with gate_en=1 since reset

## Operation
- Reset values: state HALT, gate_en 0, cmd_ready 0 during reset, step_done/bp_hit 0, en_cycles 0, step counter 0, sync chain 0.
- jtag_run passes through SYNC_STAGES flops to give jr_s; no other logic touches the raw input.
- cmd_ready = 1 in HALT, RUN, STEP; 0 in JTAG.
- HALT: gate_en 0. Precedence order: accepted command first, then jr_s=1 moves the block to JTAG.
  - RUN goes to RUN.
  - STEP with count N>0 loads the counter with N and goes to STEP.
  - STEP with N=0 is a NOP; no step_done.
  - HALT and NOP: no effect.
- RUN: gate_en 1 every cycle.
  - HALT goes to HALT.
  - STEP N>0 reloads the counter and goes to STEP.
  - RUN and NOP: no effect.
- STEP: gate_en 1 for exactly N cycles.
  - In the last cycle (counter==1), go to HALT and pulse step_done in the next cycle.
  - HALT aborts the step with no step_done.
  - RUN goes to RUN.
  - STEP N>0 reloads the counter.
- JTAG: gate_en = jr_s, registered. When jr_s falls, go to HALT. Commands are not accepted.
- en_cycles increments in each cycle where gate_en=1 and wraps at 2^CNT_W.
- Breakpoint:
  - In RUN or STEP, if bp_en and en_cycles+1 == bp_cycle during a gate_en=1 cycle, that cycle is the last enabled cycle.
  - Next cycle: gate_en 0, state HALT, bp_hit pulse.
  - If this coincides with the last STEP cycle, both step_done and bp_hit pulse.
  - The breakpoint is ignored in JTAG.
- A breakpoint stop takes priority over a command accepted in the same cycle. That command is still consumed, but its effect is discarded.
- Asserting rstn low mid-RUN, mid-STEP or mid-JTAG forces gate_en 0 immediately (asynchronous). A pending step is lost.

## Timing
- Command accepted at edge t: gate_en and state take their new values at t+1 (1-cycle latency).
- STEP N accepted at t: gate_en high in cycles t+1 … t+N, low at t+N+1; step_done high only in cycle t+N+1.
- jtag_run edge to gate_en: SYNC_STAGES+1 cycles.
- gate_en changes only on clk rising edges and comes directly from a flop, with no combinational path to BUFGCE CE.
- en_cycles lags gate_en by one cycle: registered count of the enabled cycles already completed.

## Structure
- Shared package clk_ctrl_pkg:
  - cmd_op_e enum (NOP, HALT, RUN, STEP)
  - ctrl_state_e enum (HALT, RUN, STEP, JTAG)
  - default CNT_W constant
- Sub-module sync_ff, parameterised stages, asynchronous active-low reset, used for jtag_run. All other logic is in clk_step_ctrl.

## Test plan
- Reset, then STEP N=5 at t → gate_en high cycles t+1..t+5, step_done at t+6, en_cycles=5, state HALT.
- RUN, then HALT 100 cycles later → exactly 100 gated cycles, en_cycles=100; STEP N=0 afterwards → no gate_en, no step_done.
- bp_en=1, bp_cycle=20, RUN from en_cycles=0 → gate_en drops after the 20th enabled cycle, bp_hit pulse, state HALT.
- STEP N=10 with bp_cycle=10 → both step_done and bp_hit pulse in the same cycle; STEP N=10 aborted by HALT after 4 cycles → en_cycles+4, no step_done.
- jtag_run toggled asynchronously while HALT → gate_en follows with 3-cycle latency, cmd_ready=0 throughout, return to HALT on release; en_cycles preloaded near 2^CNT_W−1 wraps to 0.
- rstn asserted mid-STEP → gate_en 0 immediately; after release, state HALT, en_cycles 0, no step_done.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared types for the gated-clock run/halt/step controller.
package clk_ctrl_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_HALT = 2'd1,
    OP_RUN  = 2'd2,
    OP_STEP = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_JTAG = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step controller driving the BUFGCE enable of the gated DUT clock.
// Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
// cmd_ready never depends on cmd_valid.
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             jtag_run,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             bp_en,
  input  logic [CNT_W-1:0] bp_cycle,
  output logic             gate_en,
  output logic [1:0]       state,
  output logic             step_done,
  output logic             bp_hit,
  output logic [CNT_W-1:0] en_cycles
);

  localparam logic [1:0] S_HALT = ST_HALT;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_STEP = ST_STEP;
  localparam logic [1:0] S_JTAG = ST_JTAG;

  logic             jr_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] en_cycles_q;
  logic             gate_en_q, gate_en_d;
  logic             step_done_q, step_done_d;
  logic             bp_hit_q, bp_hit_d;
  logic             cmd_acc, step_ok, step_last, bp_stop;

  sync_ff #(.STAGES(SYNC_STAGES)) u_jtag_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (jtag_run),
    .q    (jr_s)
  );

  assign cmd_ready = rstn & (state_q != S_JTAG);
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign step_ok   = (cmd_op == OP_STEP) && (cmd_count != '0);
  assign step_last = (state_q == S_STEP) && (cnt_q == CNT_W'(1));
  assign bp_stop   = bp_en && gate_en_q && ((state_q == S_RUN) || (state_q == S_STEP)) &&
                     ((en_cycles_q + CNT_W'(1)) == bp_cycle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_done_d = 1'b0;
    bp_hit_d    = 1'b0;
    case (state_q)
      S_HALT: begin
        if (cmd_acc && cmd_op == OP_RUN) begin
          state_d = S_RUN;
        end else if (cmd_acc && step_ok) begin
          cnt_d   = cmd_count;
          state_d = S_STEP;
        end else if (jr_s) begin
          state_d = S_JTAG;
        end
      end
      S_RUN: begin
        if (cmd_acc && cmd_op == OP_HALT) begin
          state_d = S_HALT;
        end else if (cmd_acc && step_ok) begin
          cnt_d   = cmd_count;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cmd_acc && cmd_op == OP_HALT) begin
          state_d = S_HALT;
        end else if (cmd_acc && cmd_op == OP_RUN) begin
          state_d = S_RUN;
        end else if (cmd_acc && step_ok) begin
          cnt_d = cmd_count;
        end else if (step_last) begin
          state_d     = S_HALT;
          step_done_d = 1'b1;
        end
      end
      S_JTAG: begin
        if (!jr_s) state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
    // A breakpoint overrides whatever command landed in the same cycle.
    if (bp_stop) begin
      state_d     = S_HALT;
      bp_hit_d    = 1'b1;
      step_done_d = step_last;
    end
  end

  assign gate_en_d = (state_d == S_RUN) || (state_d == S_STEP) ||
                     ((state_d == S_JTAG) && jr_s);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_HALT;
      cnt_q       <= '0;
      en_cycles_q <= '0;
      gate_en_q   <= 1'b0;
      step_done_q <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gate_en_q   <= gate_en_d;
      step_done_q <= step_done_d;
      bp_hit_q    <= bp_hit_d;
      if (gate_en_q) en_cycles_q <= en_cycles_q + CNT_W'(1);
    end
  end

  assign gate_en   = gate_en_q;
  assign state     = state_q;
  assign step_done = step_done_q;
  assign bp_hit    = bp_hit_q;
  assign en_cycles = en_cycles_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl: stepping, run/halt, breakpoints, JTAG run, wrap and reset.
module tb_clk_step_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             jtag_run = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             bp_en = 1'b0;
  logic [CNT_W-1:0] bp_cycle = '0;
  logic             gate_en;
  logic [1:0]       state;
  logic             step_done;
  logic             bp_hit;
  logic [CNT_W-1:0] en_cycles;

  int checks = 0;
  int failures = 0;
  int gated;
  logic [0:0] exp_q[$];

  clk_step_ctrl #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .jtag_run  (jtag_run),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .bp_en     (bp_en),
    .bp_cycle  (bp_cycle),
    .gate_en   (gate_en),
    .state     (state),
    .step_done (step_done),
    .bp_hit    (bp_hit),
    .en_cycles (en_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] count);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = count;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_count = '0;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    jtag_run  = 1'b0;
    cmd_valid = 1'b0;
    bp_en     = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #1 rstn = 1'b0;
    #1;
    check("rst_gate", gate_en, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_state", state, 0);
    check("rst_en", en_cycles, 0);
    check("rst_pulses", {step_done, bp_hit}, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("idle_ready", cmd_ready, 1);

    // STEP 5: gate high for exactly five cycles, step_done in the sixth
    send(2'd3, 8'd5);
    for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 5; i++) begin
      check("step5_gate", gate_en, exp_q.pop_front());
      check("step5_state", state, 2);
      check("step5_done_early", step_done, 0);
      tick();
    end
    check("step5_gate_off", gate_en, 0);
    check("step5_done", step_done, 1);
    check("step5_state_halt", state, 0);
    check("step5_en", en_cycles, 5);
    tick();
    check("step5_done_pulse", step_done, 0);

    // RUN for 100 cycles then HALT
    gated = 0;
    send(2'd2, 8'd0);
    check("run_state", state, 1);
    gated += int'(gate_en);
    for (int i = 0; i < 99; i++) begin
      tick();
      gated += int'(gate_en);
    end
    send(2'd1, 8'd0);
    check("run_gated", gated, 100);
    check("halt_gate", gate_en, 0);
    check("halt_state", state, 0);
    check("run_en", en_cycles, 105);

    // STEP 0 is a no-op
    send(2'd3, 8'd0);
    check("step0_gate", gate_en, 0);
    check("step0_state", state, 0);
    check("step0_done", step_done, 0);
    tick();
    check("step0_gate2", gate_en, 0);
    check("step0_done2", step_done, 0);

    // Breakpoint at cycle 20 during RUN
    do_reset();
    bp_en = 1'b1;
    bp_cycle = 8'd20;
    send(2'd2, 8'd0);
    for (int i = 0; i < 19; i++) begin
      check("bp_run_gate", gate_en, 1);
      check("bp_run_hit", bp_hit, 0);
      tick();
    end
    check("bp_last_gate", gate_en, 1);
    tick();
    check("bp_gate_off", gate_en, 0);
    check("bp_hit", bp_hit, 1);
    check("bp_state", state, 0);
    tick();
    check("bp_hit_pulse", bp_hit, 0);
    check("bp_en_cycles", en_cycles, 20);
    bp_en = 1'b0;

    // STEP 10 with breakpoint on its last cycle
    do_reset();
    bp_en = 1'b1;
    bp_cycle = 8'd10;
    send(2'd3, 8'd10);
    for (int i = 0; i < 9; i++) tick();
    check("stepbp_gate", gate_en, 1);
    check("stepbp_early", {step_done, bp_hit}, 0);
    tick();
    check("stepbp_both", {step_done, bp_hit}, 3);
    check("stepbp_gate_off", gate_en, 0);
    check("stepbp_state", state, 0);
    tick();
    check("stepbp_en", en_cycles, 10);
    bp_en = 1'b0;

    // STEP 10 aborted by HALT after four gated cycles
    send(2'd3, 8'd10);
    tick();
    tick();
    tick();
    check("abort_state", state, 2);
    send(2'd1, 8'd0);
    check("abort_gate", gate_en, 0);
    check("abort_state_halt", state, 0);
    check("abort_done", step_done, 0);
    tick();
    check("abort_done2", step_done, 0);
    check("abort_en", en_cycles, 14);

    // JTAG run request, breakpoint armed but ignored
    do_reset();
    bp_en = 1'b1;
    bp_cycle = 8'd4;
    #3 jtag_run = 1'b1;
    tick();
    check("jtag_e1_gate", gate_en, 0);
    tick();
    check("jtag_e2_gate", gate_en, 0);
    check("jtag_e2_state", state, 0);
    tick();
    check("jtag_gate_on", gate_en, 1);
    check("jtag_state", state, 3);
    check("jtag_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("jtag_hold_gate", gate_en, 1);
      check("jtag_hold_ready", cmd_ready, 0);
      check("jtag_bp_ignored", bp_hit, 0);
    end
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    #3 jtag_run = 1'b0;
    tick();
    check("jtag_rel1_gate", gate_en, 1);
    tick();
    check("jtag_rel2_gate", gate_en, 1);
    tick();
    check("jtag_off_gate", gate_en, 0);
    check("jtag_off_state", state, 0);
    check("jtag_off_ready", cmd_ready, 1);
    check("jtag_en", en_cycles, 8);
    tick();
    check("jtag_after_state", state, 0);
    bp_en = 1'b0;

    // en_cycles wrap at 2^CNT_W
    do_reset();
    send(2'd2, 8'd0);
    for (int i = 0; i < 254; i++) tick();
    send(2'd1, 8'd0);
    check("wrap_pre", en_cycles, 255);
    send(2'd2, 8'd0);
    tick();
    check("wrap_zero", en_cycles, 0);
    send(2'd1, 8'd0);
    check("wrap_one", en_cycles, 1);

    // Asynchronous reset mid-STEP
    do_reset();
    send(2'd3, 8'd10);
    tick();
    tick();
    check("rststep_gate", gate_en, 1);
    #2 rstn = 1'b0;
    #1;
    check("rststep_gate_off", gate_en, 0);
    check("rststep_state", state, 0);
    check("rststep_en", en_cycles, 0);
    check("rststep_ready", cmd_ready, 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rststep_done", step_done, 0);
      check("rststep_gate_idle", gate_en, 0);
    end
    check("rststep_state_after", state, 0);
    check("rststep_en_after", en_cycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
